decoder_seq: RTL and testbench
==============================

DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 SHALL have parameter SEL_W, default 2: select width; output width OUT_W = 2**SEL_W, legal SEL_W range 1..6.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port sel  input  SEL_W  decode index (DIRECT) or start index (SCAN).
REQ-007 SHALL have port mode  input  1  0 = DIRECT, 1 = SCAN; sampled with the request.
REQ-008 SHALL have port en  input  1  output gate, sampled every cycle.
REQ-009 SHALL have port abort  input  1  synchronous scan cancel.
REQ-010 SHALL have port y  output  OUT_W  registered one-hot (or all-zero) select.
REQ-011 SHALL have port y_valid  output  1  y holds a decoded value this cycle.
REQ-012 SHALL have port busy  output  1  scan in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the final scan step.

Function
REQ-014 SHALL implement FSM states IDLE, DIRECT, SCAN, DONE.
REQ-015 SHALL accept a request on a rising edge where in_valid=1 and in_ready=1; in_ready = 1 only in IDLE and DIRECT.
REQ-016 DIRECT: on acceptance with mode=0, the next cycle SHALL show y = one-hot(sel) if en=1 else 0, y_valid=1 (latency 1), for exactly one cycle unless another request is accepted.
REQ-017 Back-to-back DIRECT requests SHALL produce one decoded cycle per accepted request, no bubble.
REQ-018 SCAN: on acceptance with mode=1, the index register SHALL load sel; the following cycles SHALL show y = one-hot(index) with index incrementing by 1 per cycle up to OUT_W-1 inclusive, i.e. OUT_W - sel steps.
REQ-019 In SCAN, busy=1 and y_valid=1 on every step; y SHALL be 0 on steps where en=0, while the index still advances.
REQ-020 After step OUT_W-1 the FSM SHALL enter DONE for one cycle: done=1, y=0, y_valid=0, busy=0, in_ready=0, then return to IDLE.
REQ-021 Index SHALL never wrap; a start at sel=OUT_W-1 yields exactly one step then DONE.
REQ-022 abort=1 in SCAN SHALL, on that edge, force IDLE with y=0, y_valid=0, busy=0, and no done pulse; abort in IDLE/DIRECT/DONE SHALL have no effect.
REQ-023 in_valid during SCAN or DONE SHALL be ignored (not queued).
REQ-024 y SHALL be at most one-hot in all states; y_valid=0 implies y=0.

Reset
REQ-025 rst_n=0 SHALL asynchronously force IDLE, index=0, y=0, y_valid=0, busy=0, done=0; in_ready SHALL be 1 once reset is released.
REQ-026 Reset asserted mid-scan SHALL discard the scan with no done pulse.

Configuration
REQ-027 Macro DECODER_SEQ_SCAN_EN defined: SCAN and DONE states and behaviour as above.
REQ-028 Macro DECODER_SEQ_SCAN_EN undefined: mode and abort SHALL be ignored, every request SHALL be treated as DIRECT, busy and done SHALL be tied to 0, and the index register SHALL be omitted.

Verification
REQ-029 SEL_W=2, reset then DIRECT sel=2, en=1 -> next cycle y=4'b0100, y_valid=1; the cycle after that y=0.
REQ-030 DIRECT sel=1,3,0 on consecutive cycles with en=1 -> y=0010, 1000, 0001 on consecutive cycles.
REQ-031 SCAN sel=1, en=1 -> y=0010, 0100, 1000 with busy=1, then done=1 for one cycle, then in_ready=1.
REQ-032 SCAN sel=0 with en=0 on the second step -> y=0001, 0000, 0100, 1000, then done; in_valid pulsed mid-scan is ignored.
REQ-033 SCAN sel=0, abort on the second step -> IDLE next cycle with y=0, done never asserted; rst_n pulsed low mid-scan -> all outputs 0 immediately.
REQ-034 Rebuild without DECODER_SEQ_SCAN_EN, request mode=1 sel=3 -> one cycle y=1000, busy=0, done=0.

Source files
------------

// File: rtl/decoder_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_seq_if
//  Purpose  : Request/response bundle for decoder_seq.
//             master = requester (drives request fields, observes decoder)
//             slave  = decoder_seq (observes request, drives y/status)
//  Revision : 1.0  initial release
// ============================================================================
interface decoder_seq_if #(
   parameter int SEL_W = 2
);
   localparam int OUT_W = 1 << SEL_W;

   logic             in_valid;   // request present
   logic             in_ready;   // decoder can accept a request
   logic [SEL_W-1:0] sel;        // decode index (DIRECT) / start index (SCAN)
   logic             mode;       // 0 = DIRECT, 1 = SCAN
   logic             en;         // output gate, sampled every cycle
   logic             abort;      // synchronous scan cancel
   logic [OUT_W-1:0] y;          // registered one-hot or all-zero select
   logic             y_valid;    // y carries a decoded value
   logic             busy;       // scan in progress
   logic             done;       // pulse after the final scan step

   modport master (
      output in_valid, sel, mode, en, abort,
      input  in_ready, y, y_valid, busy, done
   );

   modport slave (
      input  in_valid, sel, mode, en, abort,
      output in_ready, y, y_valid, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_seq
//  Purpose  : Registered binary-to-one-hot decoder with an optional scan mode
//             that walks the one-hot output from a start index up to the top
//             output line, followed by a one-cycle done pulse.
//  Config   : DECODER_SEQ_SCAN_EN -- when defined, SCAN/DONE states, abort,
//             busy and done are built; otherwise every request is DIRECT.
//  Revision : 1.0  initial release
// ============================================================================
module decoder_seq #(
   parameter int SEL_W = 2              // legal range 1..6
) (
   input  logic         clk,
   input  logic         rst_n,
   decoder_seq_if.slave bus
);

   localparam int OUT_W = 1 << SEL_W;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DIRECT = 2'd1;
`ifdef DECODER_SEQ_SCAN_EN
   localparam logic [1:0] ST_SCAN   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;
`endif

   logic [1:0]       state_q, state_d;
   logic [OUT_W-1:0] y_q, y_d;
   logic             w_accept;

`ifdef DECODER_SEQ_SCAN_EN
   logic [SEL_W-1:0] idx_q, idx_d;
`else
   // mode and abort have no meaning without the scan machinery
   logic             w_unused_ok;
   assign w_unused_ok = bus.mode ^ bus.abort;
`endif

   // One-hot of idx, forced to zero when the output gate is closed
   function automatic logic [OUT_W-1:0] decode_gated(input logic [SEL_W-1:0] idx,
                                                     input logic             gate);
      logic [OUT_W-1:0] v;
      v = '0;
      if (gate) begin
         v[idx] = 1'b1;
      end
      return v;
   endfunction

   // Requests are taken only when not scanning and not signalling done
   assign bus.in_ready = (state_q == ST_IDLE) || (state_q == ST_DIRECT);
   assign w_accept     = bus.in_valid && bus.in_ready;

   // Next-state, next index and next decoded value
   always_comb begin
      state_d = state_q;
      y_d     = '0;
`ifdef DECODER_SEQ_SCAN_EN
      idx_d   = idx_q;
`endif
      case (state_q)
         ST_IDLE, ST_DIRECT: begin
            if (w_accept) begin
`ifdef DECODER_SEQ_SCAN_EN
               if (bus.mode) begin
                  // First scan step shows the start index itself
                  state_d = ST_SCAN;
                  idx_d   = bus.sel;
               end else begin
                  state_d = ST_DIRECT;
               end
`else
               state_d = ST_DIRECT;
`endif
               y_d = decode_gated(bus.sel, bus.en);
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef DECODER_SEQ_SCAN_EN
         ST_SCAN: begin
            if (bus.abort) begin
               // Cancel silently: no done pulse
               state_d = ST_IDLE;
            end else if (&idx_q) begin
               // Top line already shown; never wrap the index
               state_d = ST_DONE;
            end else begin
               state_d = ST_SCAN;
               idx_d   = idx_q + 1'b1;
               y_d     = decode_gated(idx_q + 1'b1, bus.en);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control state and registered output; reset discards any scan in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
      end
   end

`ifdef DECODER_SEQ_SCAN_EN
   // Scan position register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign bus.y_valid = (state_q == ST_DIRECT) || (state_q == ST_SCAN);
   assign bus.busy    = (state_q == ST_SCAN);
   assign bus.done    = (state_q == ST_DONE);
`else
   assign bus.y_valid = (state_q == ST_DIRECT);
   assign bus.busy    = 1'b0;
   assign bus.done    = 1'b0;
`endif

   assign bus.y = y_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_seq
//  Purpose  : Self-checking bench for decoder_seq: directed vector table,
//             hand-written abort/reset sequences and randomized traffic
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_seq;

   localparam int SEL_W = 2;
   localparam int OUT_W = 1 << SEL_W;
`ifdef DECODER_SEQ_SCAN_EN
   localparam bit SCAN_EN = 1'b1;
`else
   localparam bit SCAN_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   decoder_seq_if #(.SEL_W(SEL_W)) bus ();

   decoder_seq #(.SEL_W(SEL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic             v;
      logic [SEL_W-1:0] sel;
      logic             mode;
      logic             en;
      logic             ab;
      logic [OUT_W-1:0] y;
      logic             yv;
      logic             bsy;
      logic             dn;
      logic             rdy;
   } vec_t;

   vec_t tbl[$];

   // ---------------- reference model: list of pending scan indices --------
   logic [OUT_W-1:0] m_y;
   bit               m_yv, m_busy, m_done;
   int               m_rest[$];

   task automatic model_reset();
      m_y = '0; m_yv = 0; m_busy = 0; m_done = 0;
      m_rest.delete();
   endtask

   task automatic model_idle();
      m_y = '0; m_yv = 0; m_busy = 0; m_done = 0;
      m_rest.delete();
   endtask

   task automatic model_edge(input bit v, input int sel, input bit mode,
                             input bit en, input bit ab);
      if (m_busy) begin
         if (ab) begin
            model_idle();
         end else if (m_rest.size() == 0) begin
            m_y = '0; m_yv = 0; m_busy = 0; m_done = 1;
         end else begin
            int k;
            k    = m_rest.pop_front();
            m_y  = '0;
            if (en) m_y[k] = 1'b1;
            m_yv = 1;
         end
      end else if (m_done) begin
         model_idle();
      end else if (v) begin
         m_rest.delete();
         if (SCAN_EN && mode) begin
            for (int k = sel + 1; k < OUT_W; k++) m_rest.push_back(k);
            m_busy = 1;
         end
         m_y = '0;
         if (en) m_y[sel] = 1'b1;
         m_yv = 1;
      end else begin
         model_idle();
      end
   endtask

   // ---------------- stimulus / checking helpers --------------------------
   task automatic drive(input bit v, input logic [SEL_W-1:0] sel, input bit mode,
                        input bit en, input bit ab);
      bus.in_valid = v;
      bus.sel      = sel;
      bus.mode     = mode;
      bus.en       = en;
      bus.abort    = ab;
   endtask

   // Called at a negedge: apply inputs, clock once, land on the next negedge
   task automatic cycle(input bit v, input logic [SEL_W-1:0] sel, input bit mode,
                        input bit en, input bit ab);
      drive(v, sel, mode, en, ab);
      @(posedge clk);
      model_edge(v, int'(sel), mode, en, ab);
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [OUT_W-1:0] ey, input logic eyv,
                        input logic eb, input logic ed, input logic er, input bit chk_rdy);
      total++;
      if (bus.y !== ey || bus.y_valid !== eyv || bus.busy !== eb || bus.done !== ed ||
          (chk_rdy && bus.in_ready !== er)) begin
         bad++;
         $display("FAIL %s: got y=%b yv=%b busy=%b done=%b rdy=%b, want y=%b yv=%b busy=%b done=%b rdy=%b",
                  name, bus.y, bus.y_valid, bus.busy, bus.done, bus.in_ready,
                  ey, eyv, eb, ed, er);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [SEL_W-1:0] sel, input logic mode,
                               input logic en, input logic ab, input logic [OUT_W-1:0] y,
                               input logic yv, input logic bsy, input logic dn, input logic rdy);
      vec_t r;
      r.v = v; r.sel = sel; r.mode = mode; r.en = en; r.ab = ab;
      r.y = y; r.yv = yv; r.bsy = bsy; r.dn = dn; r.rdy = rdy;
      return r;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, '0, 0, 1, 0);
      #1;
      check("reset_hold", '0, 0, 0, 0, 1, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1;
      check("reset_release", '0, 0, 0, 0, 1, 1);
      @(negedge clk);
   endtask

   // ---------------- main sequence ----------------------------------------
   initial begin
      rst_n = 1'b0;
      drive(0, '0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      do_reset();

`ifdef DECODER_SEQ_SCAN_EN
      //            v  sel   m  en ab   y        yv b  d  rdy
      tbl.push_back(mk(1, 2'd2, 0, 1, 0, 4'b0100, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd1, 0, 1, 0, 4'b0010, 1, 0, 0, 1));
      tbl.push_back(mk(1, 2'd3, 0, 1, 0, 4'b1000, 1, 0, 0, 1));
      tbl.push_back(mk(1, 2'd0, 0, 1, 0, 4'b0001, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd1, 1, 1, 0, 4'b0010, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0100, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b1000, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd0, 1, 1, 0, 4'b0001, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2'd0, 0, 0, 0, 4'b0000, 1, 1, 0, 0));
      tbl.push_back(mk(1, 2'd2, 0, 1, 0, 4'b0100, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b1000, 1, 1, 0, 0));
      tbl.push_back(mk(1, 2'd1, 0, 1, 0, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd3, 0, 0, 0, 4'b0000, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd1, 0, 1, 1, 4'b0010, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2'd0, 0, 1, 1, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd3, 1, 1, 0, 4'b1000, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 1, 0));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd2, 0, 1, 0, 4'b0100, 1, 0, 0, 1));
      tbl.push_back(mk(1, 2'd1, 1, 1, 0, 4'b0010, 1, 1, 0, 0));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0100, 1, 1, 0, 0));
`else
      tbl.push_back(mk(1, 2'd2, 0, 1, 0, 4'b0100, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd1, 0, 1, 0, 4'b0010, 1, 0, 0, 1));
      tbl.push_back(mk(1, 2'd3, 0, 1, 0, 4'b1000, 1, 0, 0, 1));
      tbl.push_back(mk(1, 2'd0, 0, 1, 0, 4'b0001, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd3, 1, 1, 0, 4'b1000, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2'd0, 1, 1, 1, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd0, 1, 0, 1, 4'b0000, 1, 0, 0, 1));
      tbl.push_back(mk(1, 2'd2, 1, 1, 0, 4'b0100, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
      tbl.push_back(mk(1, 2'd1, 0, 1, 1, 4'b0010, 1, 0, 0, 1));
      tbl.push_back(mk(0, 2'd0, 0, 1, 0, 4'b0000, 0, 0, 0, 1));
`endif
      foreach (tbl[i]) begin
         cycle(tbl[i].v, tbl[i].sel, tbl[i].mode, tbl[i].en, tbl[i].ab);
         check($sformatf("vec%0d", i), tbl[i].y, tbl[i].yv, tbl[i].bsy, tbl[i].dn, tbl[i].rdy, 1);
      end

      // ---- hand-written multi-cycle corner cases ----
      do_reset();
`ifdef DECODER_SEQ_SCAN_EN
      // abort on the second scan step: back to IDLE, no done pulse afterwards
      cycle(1, 2'd0, 1, 1, 0);
      check("abort_step1", 4'b0001, 1, 1, 0, 0, 1);
      cycle(0, 2'd0, 0, 1, 0);
      check("abort_step2", 4'b0010, 1, 1, 0, 0, 1);
      cycle(0, 2'd0, 0, 1, 1);
      check("abort_idle", 4'b0000, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 2'd0, 0, 1, 0);
         check("abort_no_done", 4'b0000, 0, 0, 0, 1, 1);
      end
      // reset pulsed mid-scan: outputs clear at once, no done later
      cycle(1, 2'd0, 1, 1, 0);
      cycle(0, 2'd0, 0, 1, 0);
      check("rst_scan_pre", 4'b0010, 1, 1, 0, 0, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_scan_async", 4'b0000, 0, 0, 0, 1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(0, 2'd0, 0, 1, 0);
         check("rst_scan_no_done", 4'b0000, 0, 0, 0, 1, 1);
      end
`else
      // reset pulsed while a DIRECT result is showing
      cycle(1, 2'd3, 1, 1, 0);
      check("rst_dir_pre", 4'b1000, 1, 0, 0, 1, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_dir_async", 4'b0000, 0, 0, 0, 1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      cycle(0, 2'd0, 0, 1, 0);
      check("rst_dir_after", 4'b0000, 0, 0, 0, 1, 1);
`endif

      // ---- randomized traffic against the reference model ----
      do_reset();
      for (int n = 0; n < 600; n++) begin
         bit v, md, en, ab;
         logic [SEL_W-1:0] s;
         v  = ($urandom_range(99, 0) < 55);
         md = $urandom_range(1, 0) == 1;
         en = ($urandom_range(3, 0) != 0);
         ab = ($urandom_range(15, 0) == 0);
         s  = SEL_W'($urandom_range(OUT_W - 1, 0));
         cycle(v, s, md, en, ab);
         check("rand", m_y, m_yv, m_busy, m_done, !(m_busy || m_done), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
